nios2_sysid_ext: RTL and testbench



---
 rtl/nios2_sysid_pkg.sv | 42 ++++
 rtl/nios2_sysid_ext_if.sv | 20 ++
 rtl/nios2_sysid_uptime.sv | 51 +++++
 rtl/nios2_sysid_ext.sv | 105 ++++++++++
 tb/tb_nios2_sysid_ext.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nios2_sysid_pkg.sv
// Shared register map, CAPS layout and helper functions for the nios2_sysid_ext system-ID peripheral.
package nios2_sysid_pkg;

    localparam logic [2:0] ADDR_ID      = 3'd0;
    localparam logic [2:0] ADDR_TS      = 3'd1;
    localparam logic [2:0] ADDR_SCRATCH = 3'd2;
    localparam logic [2:0] ADDR_UP_LO   = 3'd3;
    localparam logic [2:0] ADDR_UP_HI   = 3'd4;
    localparam logic [2:0] ADDR_CAPS    = 3'd5;

    localparam logic [15:0] SYSID_VERSION = 16'h0002;

    localparam int CAPS_VERSION_LSB = 16;
    localparam int CAPS_RL_LSB      = 8;
    localparam int CAPS_UPTIME_BIT  = 0;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                merged[b*8 +: 8] = new_word[b*8 +: 8];
            end else begin
                merged[b*8 +: 8] = old_word[b*8 +: 8];
            end
        end
        return merged;
    endfunction

    function automatic logic [31:0] caps_word(input logic [7:0] read_latency,
                                              input logic       uptime_present);
        logic [31:0] caps;
        caps = 32'h0000_0000;
        caps[CAPS_VERSION_LSB +: 16] = SYSID_VERSION;
        caps[CAPS_RL_LSB +: 8]       = read_latency;
        caps[CAPS_UPTIME_BIT]        = uptime_present;
        return caps;
    endfunction

endpackage

// File: rtl/nios2_sysid_ext_if.sv
// Avalon-MM slave bus bundle for nios2_sysid_ext (no waitrequest; fixed-latency reads).
interface nios2_sysid_ext_if;
    logic [2:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/nios2_sysid_uptime.sv
// Prescaled 64-bit uptime counter with a high-word shadow captured on low-word reads.
module nios2_sysid_uptime #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        snapshot,
    output logic [31:0] lo,
    output logic [31:0] hi_shadow
);

    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    logic [15:0] pre_r;
    logic [63:0] count_r;
    logic [31:0] shadow_r;
    logic        wrap_s;

    assign wrap_s = (pre_r == PRE_LAST);

    // Prescaler, count and shadow; clear outranks both a tick and a snapshot.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pre_r    <= 16'h0000;
            count_r  <= 64'h0;
            shadow_r <= 32'h0000_0000;
        end else if (clear) begin
            pre_r    <= 16'h0000;
            count_r  <= 64'h0;
            shadow_r <= 32'h0000_0000;
        end else begin
            if (wrap_s) begin
                pre_r   <= 16'h0000;
                count_r <= count_r + 64'h1;
            end else begin
                pre_r   <= pre_r + 16'h0001;
                count_r <= count_r;
            end
            if (snapshot) begin
                shadow_r <= count_r[63:32];
            end else begin
                shadow_r <= shadow_r;
            end
        end
    end

    assign lo        = count_r[31:0];
    assign hi_shadow = shadow_r;

endmodule

// File: rtl/nios2_sysid_ext.sv
// System-ID Avalon-MM slave: ID, TIMESTAMP, SCRATCH, UPTIME and CAPS registers with fixed read latency.
// Optional uptime counter enabled by defining SYSID_UPTIME_EN.
module nios2_sysid_ext
    import nios2_sysid_pkg::*;
#(
    parameter logic [31:0] ID           = 32'h0000_0001,
    parameter logic [31:0] TIMESTAMP    = 32'h0000_0000,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned PRESCALE     = 1
) (
    input logic              clock,
    input logic              reset_n,
    nios2_sysid_ext_if.slave bus
);

    localparam int RL = (READ_LATENCY < 1) ? 1 : int'(READ_LATENCY);

    logic [31:0]   scratch_r;
    logic [31:0]   rd_mux_s;
    logic [31:0]   caps_s;
    logic [31:0]   up_lo_s;
    logic [31:0]   up_hi_s;
    logic [RL-1:0] vld_r;
    logic [31:0]   dat_r [RL];

`ifdef SYSID_UPTIME_EN
    localparam logic UPTIME_PRESENT = 1'b1;
    logic clear_s;
    logic snapshot_s;

    assign clear_s    = bus.write && (bus.address == ADDR_UP_LO) && (bus.byteenable != 4'h0);
    assign snapshot_s = bus.read && (bus.address == ADDR_UP_LO);

    nios2_sysid_uptime #(
        .PRESCALE (PRESCALE)
    ) u_uptime (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (clear_s),
        .snapshot  (snapshot_s),
        .lo        (up_lo_s),
        .hi_shadow (up_hi_s)
    );
`else
    localparam logic UPTIME_PRESENT = 1'b0;
    assign up_lo_s = 32'h0000_0000;
    assign up_hi_s = 32'h0000_0000;
`endif

    assign caps_s = caps_word(8'(READ_LATENCY), UPTIME_PRESENT);

    // Read-data select from the current (pre-write) register state.
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        case (bus.address)
            ADDR_ID:      rd_mux_s = ID;
            ADDR_TS:      rd_mux_s = TIMESTAMP;
            ADDR_SCRATCH: rd_mux_s = scratch_r;
            ADDR_UP_LO:   rd_mux_s = up_lo_s;
            ADDR_UP_HI:   rd_mux_s = up_hi_s;
            ADDR_CAPS:    rd_mux_s = caps_s;
            default:      rd_mux_s = 32'h0000_0000;
        endcase
    end

    // Byte-lane writable scratch register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            scratch_r <= 32'h0000_0000;
        end else if (bus.write && (bus.address == ADDR_SCRATCH)) begin
            scratch_r <= byte_merge(scratch_r, bus.writedata, bus.byteenable);
        end else begin
            scratch_r <= scratch_r;
        end
    end

    // Read response pipeline; each stage's data only moves with a valid token so readdata holds.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            vld_r <= {RL{1'b0}};
            for (int i = 0; i < RL; i++) begin
                dat_r[i] <= 32'h0000_0000;
            end
        end else begin
            vld_r[0] <= bus.read;
            if (bus.read) begin
                dat_r[0] <= rd_mux_s;
            end else begin
                dat_r[0] <= dat_r[0];
            end
            for (int i = 1; i < RL; i++) begin
                vld_r[i] <= vld_r[i-1];
                if (vld_r[i-1]) begin
                    dat_r[i] <= dat_r[i-1];
                end else begin
                    dat_r[i] <= dat_r[i];
                end
            end
        end
    end

    assign bus.readdata      = dat_r[RL-1];
    assign bus.readdatavalid = vld_r[RL-1];

endmodule

// File: tb/tb_nios2_sysid_ext.sv
// Scoreboard bench for nios2_sysid_ext: two instances (READ_LATENCY 2 / 1) checked for data and exact response cycle.
module tb_nios2_sysid_ext;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        int          due;
    } exp_t;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } obs_t;

    localparam logic [31:0] ID_A  = 32'h50A7_A4D9;
    localparam logic [31:0] TS_A  = 32'h4C00_0000;
    localparam int          RL_A  = 2;
    localparam int          RL_B  = 1;
`ifdef SYSID_UPTIME_EN
    localparam logic UP = 1'b1;
`else
    localparam logic UP = 1'b0;
`endif
    localparam logic [31:0] CAPS_A = {16'h0002, 8'h02, 7'h00, UP};
    localparam logic [31:0] CAPS_B = {16'h0002, 8'h01, 7'h00, UP};

    logic clock = 1'b0;
    logic rst_a_n = 1'b0;
    logic rst_b_n = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    exp_t eq_a[$];
    exp_t eq_b[$];
    obs_t oq_a[$];
    obs_t oq_b[$];
    obs_t mon_a;
    obs_t mon_b;

    nios2_sysid_ext_if bus_a ();
    nios2_sysid_ext_if bus_b ();

    nios2_sysid_ext #(
        .ID           (ID_A),
        .TIMESTAMP    (TS_A),
        .READ_LATENCY (RL_A),
        .PRESCALE     (1)
    ) dut_a (
        .clock   (clock),
        .reset_n (rst_a_n),
        .bus     (bus_a)
    );

    nios2_sysid_ext #(
        .READ_LATENCY (RL_B),
        .PRESCALE     (4)
    ) dut_b (
        .clock   (clock),
        .reset_n (rst_b_n),
        .bus     (bus_b)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Record every response with the cycle it was seen in.
    always @(negedge clock) begin
        if (bus_a.readdatavalid) begin
            mon_a.data = bus_a.readdata;
            mon_a.cyc  = cyc;
            oq_a.push_back(mon_a);
        end
        if (bus_b.readdatavalid) begin
            mon_b.data = bus_b.readdata;
            mon_b.cyc  = cyc;
            oq_b.push_back(mon_b);
        end
    end

    task automatic issue(input bit sel, input bit rd, input bit wr, input logic [2:0] addr,
                         input logic [31:0] wd, input logic [3:0] be, input bit track,
                         input logic [31:0] lo, input logic [31:0] hi);
        exp_t e;
        e.lo = lo;
        e.hi = hi;
        if (!sel) begin
            bus_a.read = rd; bus_a.write = wr; bus_a.address = addr;
            bus_a.writedata = wd; bus_a.byteenable = be;
            e.due = cyc + RL_A;
            if (rd && track) eq_a.push_back(e);
        end else begin
            bus_b.read = rd; bus_b.write = wr; bus_b.address = addr;
            bus_b.writedata = wd; bus_b.byteenable = be;
            e.due = cyc + RL_B;
            if (rd && track) eq_b.push_back(e);
        end
        @(posedge clock); #1;
        bus_a.read = 1'b0; bus_a.write = 1'b0;
        bus_b.read = 1'b0; bus_b.write = 1'b0;
    endtask

    task automatic rd_exp(input bit sel, input logic [2:0] addr, input logic [31:0] value);
        issue(sel, 1'b1, 1'b0, addr, 32'h0, 4'h0, 1'b1, value, value);
    endtask

    task automatic wr_reg(input bit sel, input logic [2:0] addr, input logic [31:0] wd, input logic [3:0] be);
        issue(sel, 1'b0, 1'b1, addr, wd, be, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_checks += 4;
        if (bus_a.readdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata_a: got %h want 00000000", bus_a.readdata); end
        if (bus_a.readdatavalid !== 1'b0) begin n_fail++; $display("FAIL reset_rdv_a: got %b want 0", bus_a.readdatavalid); end
        if (bus_b.readdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata_b: got %h want 00000000", bus_b.readdata); end
        if (bus_b.readdatavalid !== 1'b0) begin n_fail++; $display("FAIL reset_rdv_b: got %b want 0", bus_b.readdatavalid); end
        @(posedge clock); #1;
        rst_a_n = 1'b1;
        rst_b_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        obs_t o;
        rd_exp(1'b0, 3'd0, ID_A);
        rd_exp(1'b0, 3'd1, TS_A);
        rd_exp(1'b0, 3'd5, CAPS_A);
        repeat (RL_A + 3) @(posedge clock);
        @(negedge clock);
        n_checks += 2;
        if (bus_a.readdatavalid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_rdv: got %b want 0", bus_a.readdatavalid); end
        if (bus_a.readdata !== CAPS_A) begin n_fail++; $display("FAIL b2b_hold: got %h want %h", bus_a.readdata, CAPS_A); end
        n_checks++;
        if (oq_a.size() != eq_a.size()) begin n_fail++; $display("FAIL b2b_count: got %0d responses want %0d", oq_a.size(), eq_a.size()); end
        while (eq_a.size() != 0 && oq_a.size() != 0) begin
            e = eq_a.pop_front(); o = oq_a.pop_front(); n_checks++;
            if ($isunknown(o.data) || o.data < e.lo || o.data > e.hi || o.cyc != e.due) begin
                n_fail++; $display("FAIL b2b_rsp: got %h at cycle %0d want %h..%h at cycle %0d", o.data, o.cyc, e.lo, e.hi, e.due);
            end
        end
        eq_a.delete(); oq_a.delete();
    endtask

    task automatic test_scratch();
        exp_t e;
        obs_t o;
        wr_reg(1'b0, 3'd2, 32'hFFFF_FFFF, 4'hF);
        wr_reg(1'b0, 3'd2, 32'h0000_0012, 4'b0001);
        rd_exp(1'b0, 3'd2, 32'hFFFF_FF12);
        wr_reg(1'b0, 3'd2, 32'h0000_0000, 4'h0);
        rd_exp(1'b0, 3'd2, 32'hFFFF_FF12);
        wr_reg(1'b0, 3'd2, 32'h0000_AB00, 4'b0110);
        rd_exp(1'b0, 3'd2, 32'hFF00_AB12);
        wr_reg(1'b0, 3'd0, 32'hDEAD_BEEF, 4'hF);
        rd_exp(1'b0, 3'd0, ID_A);
        rd_exp(1'b0, 3'd6, 32'h0);
        rd_exp(1'b0, 3'd7, 32'h0);
        wr_reg(1'b0, 3'd6, 32'hFFFF_FFFF, 4'hF);
        rd_exp(1'b0, 3'd2, 32'hFF00_AB12);
        wr_reg(1'b0, 3'd2, 32'h0000_0005, 4'hF);
        issue(1'b0, 1'b1, 1'b1, 3'd2, 32'h0000_0009, 4'hF, 1'b1, 32'h5, 32'h5);
        rd_exp(1'b0, 3'd2, 32'h0000_0009);
        repeat (RL_A + 3) @(posedge clock); #1;
        n_checks++;
        if (oq_a.size() != eq_a.size()) begin n_fail++; $display("FAIL scratch_count: got %0d responses want %0d", oq_a.size(), eq_a.size()); end
        while (eq_a.size() != 0 && oq_a.size() != 0) begin
            e = eq_a.pop_front(); o = oq_a.pop_front(); n_checks++;
            if ($isunknown(o.data) || o.data < e.lo || o.data > e.hi || o.cyc != e.due) begin
                n_fail++; $display("FAIL scratch_rsp: got %h at cycle %0d want %h..%h at cycle %0d", o.data, o.cyc, e.lo, e.hi, e.due);
            end
        end
        eq_a.delete(); oq_a.delete();
    endtask

    task automatic test_caps_defaults();
        exp_t e;
        obs_t o;
        rd_exp(1'b1, 3'd5, CAPS_B);
        rd_exp(1'b1, 3'd0, 32'h0000_0001);
        rd_exp(1'b1, 3'd1, 32'h0000_0000);
        rd_exp(1'b1, 3'd2, 32'h0000_0000);
        repeat (RL_B + 3) @(posedge clock); #1;
        n_checks++;
        if (oq_b.size() != eq_b.size()) begin n_fail++; $display("FAIL caps_count: got %0d responses want %0d", oq_b.size(), eq_b.size()); end
        while (eq_b.size() != 0 && oq_b.size() != 0) begin
            e = eq_b.pop_front(); o = oq_b.pop_front(); n_checks++;
            if ($isunknown(o.data) || o.data < e.lo || o.data > e.hi || o.cyc != e.due) begin
                n_fail++; $display("FAIL caps_rsp: got %h at cycle %0d want %h..%h at cycle %0d", o.data, o.cyc, e.lo, e.hi, e.due);
            end
        end
        eq_b.delete(); oq_b.delete();
    endtask

`ifdef SYSID_UPTIME_EN
    task automatic test_uptime();
        exp_t e;
        obs_t o;
        rst_b_n = 1'b0;
        repeat (2) @(posedge clock); #1;
        rst_b_n = 1'b1;
        repeat (40) @(posedge clock); #1;
        issue(1'b1, 1'b1, 1'b0, 3'd3, 32'h0, 4'h0, 1'b1, 32'd9, 32'd11);
        wr_reg(1'b1, 3'd3, 32'h0000_1234, 4'b0001);
        rd_exp(1'b1, 3'd3, 32'h0);
        rd_exp(1'b1, 3'd4, 32'h0);
        force dut_a.u_uptime.count_r = 64'h0000_0000_FFFF_FFFF;
        rd_exp(1'b0, 3'd3, 32'hFFFF_FFFF);
        release dut_a.u_uptime.count_r;
        repeat (2) @(posedge clock); #1;
        rd_exp(1'b0, 3'd4, 32'h0);
        issue(1'b0, 1'b1, 1'b0, 3'd3, 32'h0, 4'h0, 1'b1, 32'h0, 32'hFFFF_FFFF);
        rd_exp(1'b0, 3'd4, 32'h1);
        repeat (RL_A + 3) @(posedge clock); #1;
        n_checks += 2;
        if (oq_a.size() != eq_a.size()) begin n_fail++; $display("FAIL uptime_count_a: got %0d responses want %0d", oq_a.size(), eq_a.size()); end
        if (oq_b.size() != eq_b.size()) begin n_fail++; $display("FAIL uptime_count_b: got %0d responses want %0d", oq_b.size(), eq_b.size()); end
        while (eq_b.size() != 0 && oq_b.size() != 0) begin
            e = eq_b.pop_front(); o = oq_b.pop_front(); n_checks++;
            if ($isunknown(o.data) || o.data < e.lo || o.data > e.hi || o.cyc != e.due) begin
                n_fail++; $display("FAIL uptime_rsp_b: got %h at cycle %0d want %h..%h at cycle %0d", o.data, o.cyc, e.lo, e.hi, e.due);
            end
        end
        while (eq_a.size() != 0 && oq_a.size() != 0) begin
            e = eq_a.pop_front(); o = oq_a.pop_front(); n_checks++;
            if ($isunknown(o.data) || o.data < e.lo || o.data > e.hi || o.cyc != e.due) begin
                n_fail++; $display("FAIL uptime_rsp_a: got %h at cycle %0d want %h..%h at cycle %0d", o.data, o.cyc, e.lo, e.hi, e.due);
            end
        end
        eq_a.delete(); oq_a.delete(); eq_b.delete(); oq_b.delete();
    endtask
`else
    task automatic test_uptime_absent();
        exp_t e;
        obs_t o;
        rd_exp(1'b0, 3'd3, 32'h0);
        rd_exp(1'b0, 3'd4, 32'h0);
        wr_reg(1'b0, 3'd3, 32'hFFFF_FFFF, 4'hF);
        rd_exp(1'b0, 3'd3, 32'h0);
        rd_exp(1'b0, 3'd2, 32'h0000_0009);
        repeat (RL_A + 3) @(posedge clock); #1;
        n_checks++;
        if (oq_a.size() != eq_a.size()) begin n_fail++; $display("FAIL noup_count: got %0d responses want %0d", oq_a.size(), eq_a.size()); end
        while (eq_a.size() != 0 && oq_a.size() != 0) begin
            e = eq_a.pop_front(); o = oq_a.pop_front(); n_checks++;
            if ($isunknown(o.data) || o.data < e.lo || o.data > e.hi || o.cyc != e.due) begin
                n_fail++; $display("FAIL noup_rsp: got %h at cycle %0d want %h..%h at cycle %0d", o.data, o.cyc, e.lo, e.hi, e.due);
            end
        end
        eq_a.delete(); oq_a.delete();
    endtask
`endif

    task automatic test_reset_midop();
        exp_t e;
        obs_t o;
        wr_reg(1'b0, 3'd2, 32'h0000_ABCD, 4'hF);
        issue(1'b0, 1'b1, 1'b0, 3'd0, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0);
        rst_a_n = 1'b0;
        issue(1'b0, 1'b1, 1'b0, 3'd1, 32'h0, 4'h0, 1'b0, 32'h0, 32'h0);
        @(negedge clock);
        n_checks += 2;
        if (bus_a.readdatavalid !== 1'b0) begin n_fail++; $display("FAIL midrst_rdv: got %b want 0", bus_a.readdatavalid); end
        if (bus_a.readdata !== 32'h0) begin n_fail++; $display("FAIL midrst_rdata: got %h want 00000000", bus_a.readdata); end
        @(posedge clock); #1;
        rst_a_n = 1'b1;
        repeat (4) @(posedge clock); #1;
        n_checks++;
        if (oq_a.size() != 0) begin n_fail++; $display("FAIL midrst_dropped: got %0d responses want 0", oq_a.size()); end
        oq_a.delete();
        rd_exp(1'b0, 3'd2, 32'h0);
        repeat (RL_A + 3) @(posedge clock); #1;
        n_checks++;
        if (oq_a.size() != eq_a.size()) begin n_fail++; $display("FAIL midrst_count: got %0d responses want %0d", oq_a.size(), eq_a.size()); end
        while (eq_a.size() != 0 && oq_a.size() != 0) begin
            e = eq_a.pop_front(); o = oq_a.pop_front(); n_checks++;
            if ($isunknown(o.data) || o.data < e.lo || o.data > e.hi || o.cyc != e.due) begin
                n_fail++; $display("FAIL midrst_rsp: got %h at cycle %0d want %h..%h at cycle %0d", o.data, o.cyc, e.lo, e.hi, e.due);
            end
        end
        eq_a.delete(); oq_a.delete();
    endtask

    initial begin
        bus_a.read = 1'b0; bus_a.write = 1'b0; bus_a.address = 3'd0;
        bus_a.writedata = 32'h0; bus_a.byteenable = 4'h0;
        bus_b.read = 1'b0; bus_b.write = 1'b0; bus_b.address = 3'd0;
        bus_b.writedata = 32'h0; bus_b.byteenable = 4'h0;
        test_reset();
        test_back_to_back();
        test_scratch();
        test_caps_defaults();
`ifdef SYSID_UPTIME_EN
        test_uptime();
`else
        test_uptime_absent();
`endif
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

endmodule
